// File: rtl/hazard_sequencer_if.sv
// Pipeline-to-hazard-unit bundle: register addresses and write enables in,
// forwarding selects, stage stall/flush controls and status out.
interface hazard_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [ADDR_W-1:0] WA3E, WA3M, WA3W;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemToRegE, BranchTakenE, MemReqM, MemReadyM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic              MemTimeout;
  logic [CNT_W-1:0]  StallCycles, FlushCount;

  // Strobe-style interface: every field is a level sampled each clock; there
  // is no valid/ready pair, the pipeline obeys the stall/flush levels in the
  // same cycle they are presented.
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemTimeout, StallCycles, FlushCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemTimeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage pipeline: EX forwarding, load-use bubbles,
// branch flushes, data-memory wait sequencing with timeout, and stall/flush counters.
module hazard_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  hazard_sequencer_if.slave   hz,
  output logic [1:0]          state_dbg   // 0 RUN, 1 MEM_WAIT, 2 TIMEOUT
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic [WCW-1:0]   wait_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [1:0] fwd_a, fwd_b;
  logic       memwait, loaduse, hold;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;

  // M result is newer than W, so it wins; r0 is hardwired and never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RST_N) begin
      if (hz.RA1E != '0) begin
        if (hz.RegWriteM && hz.WA3M == hz.RA1E)      fwd_a = 2'b10;
        else if (hz.RegWriteW && hz.WA3W == hz.RA1E) fwd_a = 2'b01;
      end
      if (hz.RA2E != '0) begin
        if (hz.RegWriteM && hz.WA3M == hz.RA2E)      fwd_b = 2'b10;
        else if (hz.RegWriteW && hz.WA3W == hz.RA2E) fwd_b = 2'b01;
      end
    end
  end

  assign memwait  = hz.MemReqM && !hz.MemReadyM;
  assign loaduse  = hz.MemToRegE && hz.RegWriteE && (hz.WA3E != '0) &&
                    ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
  assign wait_nxt = wait_cnt + 1'b1;

  // A memory hold freezes every stage; a branch seen meanwhile stays in E
  // and is acted on in the release cycle.
  assign hold = (state == TIMEOUT) ||
                (state == MEM_WAIT && !hz.MemReadyM) ||
                (state == RUN && memwait);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!RST_N) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.BranchTakenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (loaduse) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_e && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      case (state)
        RUN: begin
          if (memwait) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (hz.MemReadyM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_MAX) begin
              state     <= TIMEOUT;
              timeout_q <= 1'b1;
            end
          end
        end
        TIMEOUT: begin
          state <= TIMEOUT;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.MemTimeout  = timeout_q;
  assign hz.StallCycles = stall_cnt;
  assign hz.FlushCount  = flush_cnt;
  assign state_dbg      = state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed plan steps followed by random traffic,
// all outputs compared each cycle against a rule-level reference model.
module tb_hazard_sequencer;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic       CLK;
  logic       RST_N;
  logic [1:0] state_dbg;

  hazard_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hz ();

  hazard_sequencer #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .hz(hz.slave), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // reference model: counts of waited cycles, timeout flag, event counters
  bit m_in_wait, m_to;
  int m_waited, m_stalls, m_flushes;

  task automatic model_clear();
    m_in_wait = 0; m_to = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [ADDR_W-1:0] ra);
    if (ra == 0) return 2'b00;
    if (hz.RegWriteM && hz.WA3M == ra) return 2'b10;
    if (hz.RegWriteW && hz.WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // packing: fa[19:18] fb[17:16] stall F,D,E,M[15:12] flush D,E,W[11:9] timeout[8] stalls[7:4] flushes[3:0]
  function automatic logic [19:0] ref_out();
    logic [3:0] st;
    logic [2:0] fl;
    logic       hold, lu;
    st = 4'b0000;
    fl = 3'b000;
    if (!RST_N) return {2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, 4'd0, 4'd0};
    lu = hz.MemToRegE && hz.RegWriteE && hz.WA3E != 0 &&
         (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
    hold = m_to || (m_in_wait ? !hz.MemReadyM : (hz.MemReqM && !hz.MemReadyM));
    if (hold) begin
      st = 4'b1111; fl = 3'b001;
    end else if (hz.BranchTakenE) begin
      fl = 3'b110;
    end else if (lu) begin
      st = 4'b1100; fl = 3'b010;
    end
    return {ref_fwd(hz.RA1E), ref_fwd(hz.RA2E), st, fl, m_to,
            CNT_W'(m_stalls), CNT_W'(m_flushes)};
  endfunction

  function automatic logic [19:0] dut_out();
    return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushD, hz.FlushE, hz.FlushW, hz.MemTimeout, hz.StallCycles, hz.FlushCount};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    hz.RA1D = '0; hz.RA2D = '0; hz.RA1E = '0; hz.RA2E = '0;
    hz.WA3E = '0; hz.WA3M = '0; hz.WA3W = '0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemToRegE = 0; hz.BranchTakenE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  task automatic sample(input string tag);
    @(negedge CLK);
    check(tag, 32'(dut_out()), 32'(ref_out()));
  endtask

  task automatic advance();
    logic [19:0] e;
    e = ref_out();
    @(posedge CLK);
    if (!RST_N) model_clear();
    else begin
      if (e[15]) m_stalls  = (m_stalls  < CMAX) ? m_stalls + 1  : CMAX;
      if (e[10]) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      if (!m_to) begin
        if (e[15] && e[12]) begin
          if (m_in_wait) begin
            m_waited++;
            if (m_waited == MAX_WAIT) m_to = 1;
          end else begin
            m_in_wait = 1; m_waited = 1;
          end
        end else begin
          m_in_wait = 0; m_waited = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_clear();
    advance();
    RST_N = 1'b1;
    clear_inputs();
  endtask

  initial begin
    RST_N = 1'b0;
    clear_inputs();
    model_clear();

    // reset state
    sample("reset_all");
    check("reset_flush", {hz.FlushD, hz.FlushE, hz.FlushW}, 3'b111);
    check("reset_stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM}, 4'b0000);
    check("reset_cnt", {hz.MemTimeout, hz.StallCycles, hz.FlushCount}, 9'd0);
    check("reset_state", state_dbg, 2'd0);
    advance();
    RST_N = 1'b1;

    // forwarding: M beats W, r0 never forwarded
    hz.RegWriteM = 1; hz.WA3M = 5; hz.RegWriteW = 1; hz.WA3W = 5; hz.RA1E = 5; hz.RA2E = 0;
    sample("fwd_m");
    check("fwdA_M", hz.ForwardAE, 2'b10);
    check("fwdB_r0", hz.ForwardBE, 2'b00);
    advance();
    hz.RegWriteM = 0;
    sample("fwd_w");
    check("fwdA_W", hz.ForwardAE, 2'b01);
    advance();
    clear_inputs();

    // load-use: one bubble, then forwarding from M
    hz.MemToRegE = 1; hz.RegWriteE = 1; hz.WA3E = 7; hz.RA2D = 7;
    sample("lu_bubble");
    check("lu_ctl", {hz.StallF, hz.StallD, hz.FlushE, hz.StallE}, 4'b1110);
    advance();
    clear_inputs();
    hz.RegWriteM = 1; hz.WA3M = 7; hz.RA2E = 7;
    sample("lu_after");
    check("lu_after_ctl", {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                           hz.FlushD, hz.FlushE, hz.FlushW}, 7'd0);
    check("lu_fwdB", hz.ForwardBE, 2'b10);
    check("lu_counts", {hz.StallCycles, hz.FlushCount}, {4'd1, 4'd1});
    advance();
    do_reset();

    // three-cycle memory wait
    hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      sample("mw_hold");
      check("mw_hold_ctl", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}, 5'b11111);
      advance();
    end
    hz.MemReadyM = 1;
    sample("mw_release");
    check("mw_release_ctl", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}, 5'b00000);
    check("mw_stall_cnt", hz.StallCycles, 4'd3);
    advance();
    hz.MemReqM = 0;
    check("mw_back_run", state_dbg, 2'd0);
    do_reset();

    // branch held through a wait, load-use also true at release
    hz.MemReqM = 1; hz.MemReadyM = 0; hz.BranchTakenE = 1;
    hz.MemToRegE = 1; hz.RegWriteE = 1; hz.WA3E = 3; hz.RA1D = 3;
    for (int i = 0; i < 2; i++) begin
      sample("br_wait");
      check("br_wait_ctl", {hz.FlushD, hz.FlushE, hz.StallF}, 3'b001);
      advance();
    end
    hz.MemReadyM = 1;
    sample("br_release");
    check("br_release_ctl", {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD}, 4'b1100);
    advance();
    do_reset();

    // timeout, ignored ready, counter saturation, async reset mid-cycle
    hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      sample("to_wait");
      check("to_not_yet", hz.MemTimeout, 1'b0);
      advance();
    end
    sample("to_hit");
    check("to_flag", {hz.MemTimeout, hz.StallF, hz.StallM}, 3'b111);
    check("to_state", state_dbg, 2'd2);
    advance();
    hz.MemReadyM = 1;
    for (int i = 0; i < 15; i++) begin
      sample("to_stuck");
      advance();
    end
    check("to_ignore_ready", {hz.MemTimeout, hz.StallF, hz.StallD, hz.StallE, hz.StallM}, 5'b11111);
    check("sat_stall_cnt", hz.StallCycles, 4'd15);
    #2;
    RST_N = 1'b0;
    model_clear();
    #1;
    check("async_clr", {hz.MemTimeout, hz.StallCycles, hz.FlushCount}, 9'd0);
    check("async_ctl", {hz.StallF, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW}, 5'b00111);
    RST_N = 1'b1;
    clear_inputs();
    sample("post_async");
    advance();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      hz.RA1D = ADDR_W'($urandom_range(0, 3)); hz.RA2D = ADDR_W'($urandom_range(0, 3));
      hz.RA1E = ADDR_W'($urandom_range(0, 3)); hz.RA2E = ADDR_W'($urandom_range(0, 3));
      hz.WA3E = ADDR_W'($urandom_range(0, 3)); hz.WA3M = ADDR_W'($urandom_range(0, 3));
      hz.WA3W = ADDR_W'($urandom_range(0, 3));
      hz.RegWriteE = 1'($urandom_range(0, 1)); hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1)); hz.MemToRegE = 1'($urandom_range(0, 1));
      hz.BranchTakenE = ($urandom_range(0, 4) == 0);
      hz.MemReqM   = ($urandom_range(0, 2) == 0);
      hz.MemReadyM = ($urandom_range(0, 2) == 0);
      RST_N = ($urandom_range(0, 29) != 0);
      if (!RST_N) model_clear();
      sample("rand");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
